// File: rtl/video_pkg.sv
// Shared definitions for the video subsystem: default VRAM geometry,
// grant encoding and scheduler FSM state encoding.
package video_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 8;

   typedef logic [1:0] grant_t;
   localparam grant_t GNT_NONE  = 2'd0;
   localparam grant_t GNT_FETCH = 2'd1;
   localparam grant_t GNT_WRITE = 2'd2;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_BURST = 1'b1;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO holding buffered CPU writes. Head is read combinationally,
// so an entry pushed in one cycle is poppable from the next cycle on.
module wr_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/vram_access_scheduler.sv
// Arbitrates the single-port VRAM between pixel fetches (always first) and
// buffered CPU writes, which drain only during blanking with no fetch pending.
module vram_access_scheduler
   import video_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              visible,
   input  logic              cpu_wr_valid,
   output logic              cpu_wr_ready,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata,
   output logic              wr_pending,
   output logic              drained
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CW-1:0]            fifo_count;
   logic [ADDR_W+DATA_W-1:0] head;
   logic                     push;
   logic                     pop;
   logic                     last_pop;
   logic                     ready_q;
   logic                     rd_pend;
   grant_t                   grant;
   state_t                   state;
   state_t                   state_next;

   // ready_q keeps the CPU side closed until the first clock after reset release.
   assign cpu_wr_ready = ready_q && !fifo_full;
   assign push         = cpu_wr_valid && cpu_wr_ready;
   assign pop          = (grant == GNT_WRITE);
   assign last_pop     = pop && !push && (fifo_count == CW'(1));
   assign wr_pending   = !fifo_empty;
   assign fetch_rdata  = fetch_rvalid ? vram_rdata : '0;

   wr_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({cpu_wr_addr, cpu_wr_data}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      grant = GNT_NONE;
      if (fetch_req)
         grant = GNT_FETCH;
      else if (!visible && !fifo_empty)
         grant = GNT_WRITE;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (pop) state_next = ST_BURST;
         ST_BURST: if (!pop || last_pop) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Read data arrives one cycle after the address, hence the two-stage valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         ready_q      <= 1'b0;
         vram_addr    <= '0;
         vram_we      <= 1'b0;
         vram_wdata   <= '0;
         rd_pend      <= 1'b0;
         fetch_rvalid <= 1'b0;
         drained      <= 1'b0;
      end else begin
         state        <= state_next;
         ready_q      <= 1'b1;
         vram_we      <= pop;
         rd_pend      <= (grant == GNT_FETCH);
         fetch_rvalid <= rd_pend;
         drained      <= last_pop;
         case (grant)
            GNT_FETCH: vram_addr <= fetch_addr;
            GNT_WRITE: begin
               vram_addr  <= head[ADDR_W+DATA_W-1:DATA_W];
               vram_wdata <= head[DATA_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Scoreboard bench for vram_access_scheduler with a synchronous VRAM model.
module tb_vram_access_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        visible = 1'b1;
   logic        cpu_wr_valid = 1'b0;
   logic        cpu_wr_ready;
   logic [11:0] cpu_wr_addr = '0;
   logic [7:0]  cpu_wr_data = '0;
   logic        fetch_req = 1'b0;
   logic [11:0] fetch_addr = '0;
   logic        fetch_rvalid;
   logic [7:0]  fetch_rdata;
   logic [11:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata = '0;
   logic        wr_pending;
   logic        drained;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } rd_exp_t;

   rd_exp_t      rd_q[$];
   logic [19:0]  wr_q[$];
   rd_exp_t      rd_e;
   logic [19:0]  wr_e;
   logic [7:0]   ram [4096];
   int           cyc = 0;
   int           vec_cnt = 0;
   int           err_cnt = 0;
   int           wr_seen = 0;
   int           drained_cnt = 0;
   int           we_starts = 0;
   logic         we_prev = 1'b0;
   logic         vis_g = 1'b1;
   logic         fr_g = 1'b0;

   always #5 clk = ~clk;

   vram_access_scheduler #(.ADDR_W(12), .DATA_W(8), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .visible      (visible),
      .cpu_wr_valid (cpu_wr_valid),
      .cpu_wr_ready (cpu_wr_ready),
      .cpu_wr_addr  (cpu_wr_addr),
      .cpu_wr_data  (cpu_wr_data),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_rvalid (fetch_rvalid),
      .fetch_rdata  (fetch_rdata),
      .vram_addr    (vram_addr),
      .vram_we      (vram_we),
      .vram_wdata   (vram_wdata),
      .vram_rdata   (vram_rdata),
      .wr_pending   (wr_pending),
      .drained      (drained)
   );

   function automatic logic [7:0] pat(input logic [11:0] a);
      logic [11:0] t;
      t = a * 12'd7 + 12'd3;
      return t[7:0] ^ 8'h5A;
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = pat(12'(i));
   end

   always @(posedge clk) begin
      if (vram_we) ram[vram_addr] <= vram_wdata;
      vram_rdata <= ram[vram_addr];
      cyc   <= cyc + 1;
      vis_g <= visible;
      fr_g  <= fetch_req;
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every read and write the DUT issues is matched in order.
   always @(negedge clk) begin
      if (fetch_rvalid) begin
         if (rd_q.size() == 0) check_output("unexpected_rvalid", 1, 0);
         else begin
            rd_e = rd_q.pop_front();
            check_output("rdata", fetch_rdata, rd_e.data);
            check_output("rd_latency", cyc - rd_e.cyc, 2);
         end
      end
      if (vram_we) begin
         check_output("we_blocked", {vis_g, fr_g}, 0);
         if (wr_q.size() == 0) check_output("unexpected_write", 1, 0);
         else begin
            wr_e = wr_q.pop_front();
            check_output("wr_entry", {vram_addr, vram_wdata}, wr_e);
         end
         wr_seen++;
         if (!we_prev) we_starts++;
      end
      we_prev = vram_we;
      if (drained) drained_cnt++;
   end

   task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
      int n = 0;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = a;
      cpu_wr_data  = d;
      while (!cpu_wr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_wr_ready) check_output("wr_accept_timeout", 0, 1);
      else wr_q.push_back({a, d});
      @(negedge clk);
      cpu_wr_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((wr_q.size() != 0 || wr_pending) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_output("drain_done", (wr_q.size() == 0 && !wr_pending), 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_ready", cpu_wr_ready, 0);
      check_output("rst_we", vram_we, 0);
      check_output("rst_pending", wr_pending, 0);
      check_output("rst_addr", vram_addr, 0);
      check_output("rst_rvalid", fetch_rvalid, 0);
      rst = 1'b1;
      @(negedge clk);
      check_output("ready_after_rst", cpu_wr_ready, 1);

      // Fetch priority while visible, writes queued alongside
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               fetch_req  = 1'b1;
               fetch_addr = 12'(i);
               rd_q.push_back('{cyc, pat(12'(i))});
               @(negedge clk);
            end
            fetch_req = 1'b0;
         end
         begin
            cpu_write(12'h200, 8'h11);
            cpu_write(12'h201, 8'h22);
            cpu_write(12'h202, 8'h33);
         end
      join
      repeat (4) @(negedge clk);
      check_output("rd_all_returned", rd_q.size(), 0);
      check_output("no_we_visible", wr_seen, 0);
      check_output("pending_visible", wr_pending, 1);
      visible = 1'b0;
      wait_drain();

      // Blank drain of two entries
      visible = 1'b1;
      cpu_write(12'h123, 8'hAA);
      cpu_write(12'h124, 8'hBB);
      repeat (2) @(negedge clk);
      drained_cnt = 0;
      we_starts   = 0;
      wr_seen     = 0;
      visible     = 1'b0;
      wait_drain();
      check_output("blank_drained_once", drained_cnt, 1);
      check_output("blank_back_to_back", we_starts, 1);
      check_output("blank_writes", wr_seen, 2);
      check_output("blank_pending", wr_pending, 0);

      // Full FIFO, fifth write held until a pop frees a slot
      visible = 1'b1;
      wr_seen = 0;
      for (int i = 0; i < 4; i++) cpu_write(12'(12'h300 + i), 8'(8'h40 + i));
      check_output("full_ready", cpu_wr_ready, 0);
      fork
         cpu_write(12'h304, 8'h44);
         begin
            repeat (5) @(negedge clk);
            check_output("fifth_held", wr_q.size(), 4);
            check_output("full_ready_held", cpu_wr_ready, 0);
            visible = 1'b0;
         end
      join
      wait_drain();
      check_output("full_writes", wr_seen, 5);

      // Burst interrupted by visible after two writes
      visible = 1'b1;
      for (int i = 0; i < 4; i++) cpu_write(12'(12'h400 + i), 8'(8'h70 + i));
      wr_seen = 0;
      visible = 1'b0;
      @(negedge clk);
      @(negedge clk);
      visible = 1'b1;
      repeat (4) @(negedge clk);
      check_output("intr_written", wr_seen, 2);
      check_output("intr_pending", wr_pending, 1);
      visible = 1'b0;
      wait_drain();
      check_output("intr_all_written", wr_seen, 4);

      // Push and pop in the same cycle with one entry queued
      visible = 1'b1;
      cpu_write(12'h500, 8'h55);
      drained_cnt  = 0;
      visible      = 1'b0;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 12'h501;
      cpu_wr_data  = 8'h66;
      check_output("simul_ready", cpu_wr_ready, 1);
      wr_q.push_back({12'h501, 8'h66});
      @(negedge clk);
      visible      = 1'b1;
      cpu_wr_valid = 1'b0;
      check_output("simul_pending", wr_pending, 1);
      check_output("simul_no_drained", drained, 0);
      repeat (3) @(negedge clk);
      check_output("simul_drained_cnt", drained_cnt, 0);
      check_output("simul_still_pending", wr_pending, 1);
      visible = 1'b0;
      wait_drain();
      check_output("simul_final_drained", drained_cnt, 1);

      // Asynchronous reset in the middle of a burst
      visible = 1'b1;
      for (int i = 0; i < 4; i++) cpu_write(12'(12'h600 + i), 8'(8'h90 + i));
      visible = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_output("arst_we", vram_we, 0);
      check_output("arst_ready", cpu_wr_ready, 0);
      check_output("arst_pending", wr_pending, 0);
      check_output("arst_addr", vram_addr, 0);
      check_output("arst_wdata", vram_wdata, 0);
      wr_q.delete();
      repeat (2) @(negedge clk);
      rst     = 1'b1;
      wr_seen = 0;
      repeat (10) @(negedge clk);
      check_output("post_rst_pending", wr_pending, 0);
      check_output("post_rst_no_writes", wr_seen, 0);
      check_output("post_rst_ready", cpu_wr_ready, 1);

      check_output("rd_q_empty", rd_q.size(), 0);
      check_output("wr_q_empty", wr_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
